// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: command codes, legality test
// and the sequencer's FSM state encoding.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE       = 4'd0;
  localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
  localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
  localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
  localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX         = 4'd5;
  localparam logic [3:0] CMD_MIN         = 4'd6;
  localparam logic [3:0] CMD_AVG         = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW     = 4'd8;
  localparam logic [3:0] CMD_ROT_CW      = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;
  localparam logic [3:0] CMD_MAX_LEGAL   = CMD_MIRROR_Y;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_GAP     = 2'd2;
  localparam state_t ST_WAIT_WR = 2'd3;

  function automatic logic is_legal(input logic [3:0] code);
    return code <= CMD_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; pointers wrap mod DEPTH and the
// occupancy count is the registered source of full/empty/level.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates every read,
  // so stale entries are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues host commands and issues them one at a time to the LCD controller,
// tracking write-back completion, frame count and sticky error flags.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   flush,
  input  logic                   ctrl_busy,
  input  logic                   ctrl_done,
  output logic [3:0]             cmd,
  output logic                   cmd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             frames_done,
  output logic                   illegal_err,
  output logic                   timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          flush_now;
  logic          push;
  logic          pop;

  assign host_ready = !full;

  // NOTE: every always_comb output gets a default first so no path through
  // the block can leave a signal unassigned and infer a latch.
  always_comb begin
    flush_now = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    flush_now = flush && (state == ST_IDLE);
    accept    = host_valid && !full;
    push      = accept && is_legal(host_cmd) && !flush_now;
    pop       = (state == ST_IDLE) && !empty && !ctrl_busy && !flush_now;
  end

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush_now),
    .wdata (host_cmd),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // NOTE: state registers use non-blocking assignments only, so every
  // right-hand side reads the value from before this clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd         <= CMD_WRITE;
      cmd_valid   <= 1'b0;
      timer       <= '0;
      frames_done <= '0;
      illegal_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (accept && !is_legal(host_cmd)) illegal_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            cmd       <= head;
            cmd_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_GAP;
        ST_GAP: begin
          timer <= '0;
          state <= (cmd == CMD_WRITE) ? ST_WAIT_WR : ST_IDLE;
        end
        ST_WAIT_WR: begin
          // A done arriving on the last allowed cycle still counts as a frame.
          if (ctrl_done) begin
            frames_done <= frames_done + 8'd1;
            state       <= ST_IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scenario bench for lcd_cmd_sequencer: a queue-based model of which commands
// must reach the controller, in what order and with what spacing.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       flush;
  logic       ctrl_busy;
  logic       ctrl_done;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [3:0] level;
  logic [7:0] frames_done;
  logic       illegal_err;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] ev_val [$];
  int         ev_cyc [$];

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_cmd    (host_cmd),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .flush       (flush),
    .ctrl_busy   (ctrl_busy),
    .ctrl_done   (ctrl_done),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .level       (level),
    .frames_done (frames_done),
    .illegal_err (illegal_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Every issue strobe the controller sees, with the cycle it was seen in.
  always @(negedge clk) begin
    if (!reset && cmd_valid) begin
      ev_val.push_back(cmd);
      ev_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic busy);
    reset      = 1'b1;
    host_valid = 1'b0;
    host_cmd   = 4'd0;
    flush      = 1'b0;
    ctrl_done  = 1'b0;
    ctrl_busy  = busy;
    tick(2);
    reset = 1'b0;
    tick();
    ev_val.delete();
    ev_cyc.delete();
  endtask

  // Drive one transfer, waiting (bounded) for host_ready.
  task automatic send(input logic [3:0] code);
    int budget = 100;
    while (!host_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!host_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: host_ready stayed %0b, expected 1 within 100 cycles", host_ready);
    end else begin
      host_valid = 1'b1;
      host_cmd   = code;
      tick();
      host_valid = 1'b0;
    end
  endtask

  // Offer a code for exactly one cycle; report whether it could transfer.
  task automatic offer(input logic [3:0] code, output logic acc);
    acc        = host_ready;
    host_valid = 1'b1;
    host_cmd   = code;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic wait_events(input int n, input int budget);
    while (ev_val.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (ev_val.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_events: saw %0d issues, expected %0d", ev_val.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_q [$];
    exp_q = '{4'd1, 4'd4, 4'd5};
    reset = 1'b1; host_valid = 1'b0; host_cmd = 4'd0; flush = 1'b0;
    ctrl_done = 1'b0; ctrl_busy = 1'b1;
    tick(2);
    checks++; if (cmd !== 4'd0)         begin errors++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
    checks++; if (cmd_valid !== 1'b0)   begin errors++; $display("FAIL reset_cmd_valid: got %0b expected 0", cmd_valid); end
    checks++; if (host_ready !== 1'b1)  begin errors++; $display("FAIL reset_host_ready: got %0b expected 1", host_ready); end
    checks++; if (level !== 4'd0)       begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", frames_done); end
    checks++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0b expected 0", illegal_err); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", timeout_err); end
    reset = 1'b0;
    tick();
    ev_val.delete(); ev_cyc.delete();
    foreach (exp_q[i]) send(exp_q[i]);
    tick(10);
    checks++; if (ev_val.size() != 0) begin errors++; $display("FAIL busy_hold_issue: got %0d issues expected 0", ev_val.size()); end
    checks++; if (level !== 4'd3)     begin errors++; $display("FAIL busy_hold_level: got %0d expected 3", level); end
    ctrl_busy = 1'b0;
    wait_events(3, 40);
    tick(3);
    checks++; if (ev_val.size() != 3) begin errors++; $display("FAIL drain_count: got %0d expected 3", ev_val.size()); end
    for (int i = 0; i < 3 && i < ev_val.size(); i++) begin
      checks++; if (ev_val[i] !== exp_q[i]) begin errors++; $display("FAIL drain_order[%0d]: got %0d expected %0d", i, ev_val[i], exp_q[i]); end
      if (i > 0) begin
        checks++; if (ev_cyc[i] - ev_cyc[i-1] != 3) begin errors++; $display("FAIL drain_gap[%0d]: got %0d expected 3", i, ev_cyc[i] - ev_cyc[i-1]); end
      end
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", level); end
  endtask

  task automatic test_random_stream();
    logic [3:0] exp_q [$];
    logic       exp_ill = 1'b0;
    logic [3:0] code;
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) begin
      code = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        send(code);
        if (code <= 4'd11) exp_q.push_back(code);
        else exp_ill = 1'b1;
      end else begin
        tick();
      end
    end
    wait_events(exp_q.size(), 300);
    tick(4);
    checks++; if (ev_val.size() != exp_q.size()) begin errors++; $display("FAIL stream_count: got %0d expected %0d", ev_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_val.size(); i++) begin
      checks++; if (ev_val[i] !== exp_q[i]) begin errors++; $display("FAIL stream_order[%0d]: got %0d expected %0d", i, ev_val[i], exp_q[i]); end
      if (i > 0) begin
        checks++; if (ev_cyc[i] - ev_cyc[i-1] < 3) begin errors++; $display("FAIL stream_gap[%0d]: got %0d expected >=3", i, ev_cyc[i] - ev_cyc[i-1]); end
      end
    end
    checks++; if (illegal_err !== exp_ill) begin errors++; $display("FAIL stream_illegal: got %0b expected %0b", illegal_err, exp_ill); end
    checks++; if (level !== 4'd0)          begin errors++; $display("FAIL stream_level: got %0d expected 0", level); end
  endtask

  task automatic test_write();
    int         frames = 0;
    int         delay;
    int         base;
    int         c;
    logic [3:0] nxt;
    do_reset(1'b0);
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    tick();
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL done_in_idle: got %0d expected 0", frames_done); end
    for (int k = 0; k < 3; k++) begin
      delay = (k == 0) ? 66 : int'($urandom_range(2, 200));
      nxt   = 4'($urandom_range(1, 11));
      base  = ev_val.size();
      send(4'd0);
      send(nxt);
      wait_events(base + 1, 20);
      ctrl_busy = 1'b1;
      tick(delay);
      checks++; if (ev_val.size() != base + 1) begin errors++; $display("FAIL write_blocks[%0d]: got %0d issues expected %0d", k, ev_val.size(), base + 1); end
      ctrl_done = 1'b1;
      ctrl_busy = 1'b0;
      c = cyc;
      tick();
      ctrl_done = 1'b0;
      frames++;
      wait_events(base + 2, 20);
      if (ev_val.size() >= base + 2) begin
        checks++; if (ev_val[base+1] !== nxt)  begin errors++; $display("FAIL write_next_cmd[%0d]: got %0d expected %0d", k, ev_val[base+1], nxt); end
        checks++; if (ev_cyc[base+1] != c + 2) begin errors++; $display("FAIL write_next_time[%0d]: got %0d expected %0d", k, ev_cyc[base+1], c + 2); end
      end
      tick(3);
      checks++; if (frames_done !== 8'(frames)) begin errors++; $display("FAIL write_frames[%0d]: got %0d expected %0d", k, frames_done, frames); end
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL write_no_timeout: got %0b expected 0", timeout_err); end
  endtask

  task automatic test_full();
    logic [3:0] codes [9];
    logic       acc;
    do_reset(1'b1);
    foreach (codes[i]) codes[i] = 4'($urandom_range(1, 11));
    for (int i = 0; i < 8; i++) begin
      offer(codes[i], acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL full_accept[%0d]: host_ready got %0b expected 1", i, acc); end
    end
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", host_ready); end
    checks++; if (level !== 4'd8)      begin errors++; $display("FAIL full_level: got %0d expected 8", level); end
    for (int i = 0; i < 3; i++) begin
      offer(codes[8], acc);
      checks++; if (acc !== 1'b0) begin errors++; $display("FAIL full_refuse[%0d]: host_ready got %0b expected 0", i, acc); end
    end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level_held: got %0d expected 8", level); end
    ctrl_busy = 1'b0;
    send(codes[8]);
    wait_events(9, 60);
    tick(4);
    for (int i = 0; i < 9 && i < ev_val.size(); i++) begin
      checks++; if (ev_val[i] !== codes[i]) begin errors++; $display("FAIL full_order[%0d]: got %0d expected %0d", i, ev_val[i], codes[i]); end
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL full_drain_level: got %0d expected 0", level); end
  endtask

  task automatic test_illegal();
    do_reset(1'b1);
    send(4'd13);
    checks++; if (level !== 4'd0)       begin errors++; $display("FAIL illegal_level: got %0d expected 0", level); end
    checks++; if (illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %0b expected 1", illegal_err); end
    send(4'd2);
    checks++; if (level !== 4'd1)       begin errors++; $display("FAIL illegal_next_level: got %0d expected 1", level); end
    ctrl_busy = 1'b0;
    wait_events(1, 20);
    tick(6);
    checks++; if (ev_val.size() != 1)   begin errors++; $display("FAIL illegal_issue_count: got %0d expected 1", ev_val.size()); end
    if (ev_val.size() > 0) begin
      checks++; if (ev_val[0] !== 4'd2) begin errors++; $display("FAIL illegal_issue_cmd: got %0d expected 2", ev_val[0]); end
    end
    checks++; if (illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %0b expected 1", illegal_err); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    send(4'd0);
    wait_events(1, 20);
    tick(TIMEOUT + 1);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b expected 0", timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %0b expected 1", timeout_err); end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL timeout_frames: got %0d expected 0", frames_done); end
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    send(4'd6);
    wait_events(2, 20);
    tick(3);
    if (ev_val.size() >= 2) begin
      checks++; if (ev_val[1] !== 4'd6) begin errors++; $display("FAIL timeout_resume: got %0d expected 6", ev_val[1]); end
    end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL timeout_late_done: got %0d expected 0", frames_done); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b expected 1", timeout_err); end
  endtask

  task automatic test_flush_and_reset();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) send(4'($urandom_range(1, 11)));
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL flush_pre_level: got %0d expected 3", level); end
    flush      = 1'b1;
    host_valid = 1'b1;
    host_cmd   = 4'd5;
    tick();
    flush      = 1'b0;
    host_valid = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
    ctrl_busy = 1'b0;
    tick(10);
    checks++; if (ev_val.size() != 0) begin errors++; $display("FAIL flush_issue: got %0d issues expected 0", ev_val.size()); end

    send(4'd13);
    send(4'd0);
    send(4'd9);
    wait_events(1, 20);
    tick(5);
    checks++; if (level !== 4'd1)       begin errors++; $display("FAIL midrst_pre_level: got %0d expected 1", level); end
    checks++; if (illegal_err !== 1'b1) begin errors++; $display("FAIL midrst_pre_illegal: got %0b expected 1", illegal_err); end
    reset = 1'b1;
    #2;
    checks++; if (cmd_valid !== 1'b0)   begin errors++; $display("FAIL midrst_cmd_valid: got %0b expected 0", cmd_valid); end
    checks++; if (cmd !== 4'd0)         begin errors++; $display("FAIL midrst_cmd: got %0d expected 0", cmd); end
    checks++; if (host_ready !== 1'b1)  begin errors++; $display("FAIL midrst_host_ready: got %0b expected 1", host_ready); end
    checks++; if (level !== 4'd0)       begin errors++; $display("FAIL midrst_level: got %0d expected 0", level); end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL midrst_frames: got %0d expected 0", frames_done); end
    checks++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL midrst_illegal: got %0b expected 0", illegal_err); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got %0b expected 0", timeout_err); end
    tick(2);
    reset = 1'b0;
    tick(8);
    checks++; if (ev_val.size() != 1) begin errors++; $display("FAIL midrst_lost_queue: got %0d issues expected 1", ev_val.size()); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_random_stream();
    test_write();
    test_full();
    test_illegal();
    test_timeout();
    test_flush_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
